seq_shift_unit: RTL and testbench

//   Multi-cycle shift unit for the 16-bit datapath: shifts an operand by a

---
 rtl/seq_shift_unit.sv | 121 ++++++++++++
 tb/tb_seq_shift_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift unit for the 16-bit datapath.
// It shifts operand B by 'amount' bit positions, moving one position per clock.
// Shift encoding: 00 pass, 01 LSL (zero fill), 10 LSR (zero fill), 11 ASR (sign fill).
// Handshake: start is accepted only while idle. busy covers the shift cycles.
// done pulses for one cycle when result is updated. result holds its value
// until the next completion.
module seq_shift_unit #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] B,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] work;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH-1:0] shifted;

    logic             accept;
    logic             pass_now;
    logic             finish;

    // Decode the handshake events that drive both the FSM and the datapath.
    // A pass op or a zero amount completes in the accepting cycle, with no SHIFT state.
    always_comb begin
        accept   = (state == IDLE) && start;
        pass_now = accept && ((op == 2'b00) || (amount == '0));
        finish   = (state == SHIFT) && (cnt == AMT_W'(1));
    end

    // Compute the one-position shift of the working register for the latched op.
    always_comb begin
        shifted = work;
        case (op_q)
            2'b01:   shifted = {work[WIDTH-2:0], 1'b0};
            2'b10:   shifted = {1'b0, work[WIDTH-1:1]};
            2'b11:   shifted = {work[WIDTH-1], work[WIDTH-1:1]};
            default: shifted = work;
        endcase
    end

    // Hold the state register. Asserting reset aborts any shift in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Select the next state: enter SHIFT for a real shift, and leave SHIFT on the last step.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !pass_now) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (finish) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Drive busy for exactly the cycles spent in SHIFT.
    always_comb begin
        busy = (state == SHIFT);
    end

    // Update the datapath registers.
    // Operands are latched on acceptance, the working register steps once per SHIFT cycle,
    // and result and done update only on completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= 2'b00;
            work   <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (pass_now) begin
                op_q   <= op;
                result <= B;
                done   <= 1'b1;
            end else if (accept) begin
                op_q <= op;
                work <= B;
                cnt  <= amount;
            end else if (state == SHIFT) begin
                work <= shifted;
                cnt  <= cnt - AMT_W'(1);
                if (finish) begin
                    result <= shifted;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit.
// Directed steps are driven from one initial block. Each accepted start pushes its
// expected result onto a queue, and the entry is popped when done is seen.
module tb_seq_shift_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] B;
    logic [3:0]  amount;
    logic        busy;
    logic        done;
    logic [15:0] result;

    int          vectors;
    int          miscompares;
    logic [15:0] expQ[$];

    seq_shift_unit #(.WIDTH(16), .AMT_W(4)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .op     (op),
        .B      (B),
        .amount (amount),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model built from plain shift operators.
    function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] b,
                                          input logic [3:0] a);
        logic [15:0] r;
        case (o)
            2'b01:   r = b << a;
            2'b10:   r = b >> a;
            2'b11:   r = 16'($signed(b) >>> a);
            default: r = b;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one start request. The request is accepted on the next rising edge.
    // After that edge the inputs are scrambled to show that they are no longer used.
    task automatic applyStimulus(input logic [1:0] o, input logic [15:0] b,
                                 input logic [3:0] a);
        start  = 1'b1;
        op     = o;
        B      = b;
        amount = a;
        expQ.push_back(model(o, b, a));
        @(posedge clk);
        #1;
        start  = 1'b0;
        op     = 2'($urandom);
        B      = 16'($urandom);
        amount = 4'($urandom);
    endtask

    // Wait a bounded number of cycles for done.
    // Check the latency, the busy-cycle count, the result, and that done does not repeat.
    task automatic checkOutput(input string tag, input int expLat, input bit checkDrop);
        int          c       = 0;
        int          busyCnt = 0;
        bit          got     = 1'b0;
        logic [15:0] exp;
        while (!got && c <= 40) begin
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (busy === 1'b1) busyCnt++;
                @(posedge clk);
                #1;
                c++;
            end
        end
        check({tag, " done_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, " latency"}, c, expLat);
            check({tag, " busy_cycles"}, busyCnt, expLat);
            check({tag, " busy_at_done"}, 32'(busy), 32'd0);
            if (expQ.size() == 0) begin
                check({tag, " queue_entry"}, 32'd0, 32'd1);
            end else begin
                exp = expQ.pop_front();
                check({tag, " result"}, 32'(result), 32'(exp));
                if (checkDrop) begin
                    @(posedge clk);
                    #1;
                    check({tag, " done_pulse"}, 32'(done), 32'd0);
                    check({tag, " result_held"}, 32'(result), 32'(exp));
                end
            end
        end
    endtask

    initial begin
        logic [1:0]  rop;
        logic [15:0] rb;
        logic [3:0]  ramt;

        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        op          = 2'b00;
        B           = 16'h0000;
        amount      = 4'h0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic shifts.
        applyStimulus(2'b01, 16'h0001, 4'd4);
        checkOutput("lsl_1_by_4", 4, 1'b1);
        applyStimulus(2'b11, 16'h8000, 4'd15);
        checkOutput("asr_8000_by_15", 15, 1'b1);
        applyStimulus(2'b10, 16'h8000, 4'd15);
        checkOutput("lsr_8000_by_15", 15, 1'b1);

        // Zero amount and pass complete at once and never raise busy.
        applyStimulus(2'b01, 16'hABCD, 4'd0);
        checkOutput("lsl_amt0", 0, 1'b1);
        applyStimulus(2'b00, 16'h1234, 4'd7);
        checkOutput("pass_amt7", 0, 1'b1);

        // A start pulse while busy is ignored.
        applyStimulus(2'b10, 16'hF000, 4'd3);
        check("busy_before_repulse", 32'(busy), 32'd1);
        start  = 1'b1;
        op     = 2'b01;
        B      = 16'h0FFF;
        amount = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("lsr_ignore_repulse", 2, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("no_second_done", 32'(done), 32'd0);
        check("repulse_result_held", 32'(result), 32'h1E00);

        // Reset in the middle of a shift aborts it.
        applyStimulus(2'b01, 16'h00FF, 4'd8);
        @(posedge clk);
        #1;
        check("busy_midshift", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        void'(expQ.pop_back());
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle_busy", 32'(busy), 32'd0);
        check("post_reset_idle_done", 32'(done), 32'd0);
        applyStimulus(2'b01, 16'h0003, 4'd1);
        checkOutput("lsl_after_reset", 1, 1'b1);

        // Back-to-back: start again in the done cycle.
        applyStimulus(2'b10, 16'h0005, 4'd1);
        checkOutput("lsr_first_of_pair", 1, 1'b0);
        applyStimulus(2'b11, 16'hC000, 4'd2);
        checkOutput("asr_back_to_back", 2, 1'b1);

        // A few random operations checked against the model.
        for (int i = 0; i < 6; i++) begin
            rop  = 2'($urandom);
            rb   = 16'($urandom);
            ramt = 4'($urandom);
            applyStimulus(rop, rb, ramt);
            checkOutput("random_op", ((rop == 2'b00) || (ramt == 4'd0)) ? 0 : int'(ramt), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
